// File: rtl/ip_filter_sequencer.sv
// Replays one buffered packet through a shared ip_comparator once per enabled target; result after E*(L+2+CMP_LAT)+1 cycles.
// pkt_ready drops from CLEAR until the result handshake; IP_FILTER_STATS_EN adds stat_pkts/stat_hits counters.
module ip_filter_sequencer #(
    parameter int NUM_TARGETS = 4,
    parameter int MAX_WORDS   = 16,
    parameter int CMP_LAT     = 1,
    localparam int IW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1,
    localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1,
    localparam int LW = $clog2(MAX_WORDS + 1),
    localparam int DW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [IW-1:0]          cfg_idx,
    input  logic [31:0]            cfg_ip,
    input  logic                   cfg_en,
    input  logic                   pkt_valid,
    input  logic                   pkt_sop,
    input  logic                   pkt_eop,
    input  logic [31:0]            pkt_data,
    output logic                   pkt_ready,
    output logic                   cmp_clear,
    output logic [31:0]            cmp_ip,
    output logic [31:0]            cmp_data,
    input  logic                   cmp_match,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [NUM_TARGETS-1:0] res_hits,
    output logic                   res_ovf,
    output logic                   busy
`ifdef IP_FILTER_STATS_EN
    ,
    output logic [15:0]            stat_pkts,
    output logic [15:0]            stat_hits
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_CLEAR, S_REPLAY, S_FLUSH, S_DRAIN, S_REPORT
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            slot_ip_q [NUM_TARGETS];
    logic [NUM_TARGETS-1:0] slot_en_q;
    logic [31:0]            pkt_buf [MAX_WORDS];
    logic [LW-1:0]          len_q;
    logic [LW-1:0]          rd_q;
    logic [DW-1:0]          drain_q;
    logic [IW-1:0]          cur_q;
    logic [31:0]            cmp_ip_q;
    logic                   ovf_q;
    logic [NUM_TARGETS-1:0] hits_q;

    logic [IW:0]            sel_start;
    logic [IW-1:0]          sel_idx;
    logic                   sel_found;
    logic                   accept;

    assign accept = pkt_valid && pkt_ready;

    // Lowest enabled slot at or above sel_start; enables are read live so late cfg writes count.
    always_comb begin
        sel_start = (state_q == S_DRAIN) ? ({1'b0, cur_q} + (IW+1)'(1)) : '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (!sel_found && slot_en_q[i] && i >= int'(sel_start)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pkt_ready = 1'b0;
        cmp_clear = 1'b0;
        cmp_data  = '0;
        res_valid = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid && pkt_sop)
                    state_d = pkt_eop ? (sel_found ? S_CLEAR : S_REPORT) : S_CAPTURE;
            end
            S_CAPTURE: begin
                pkt_ready = 1'b1;
                if (pkt_valid && pkt_eop)
                    state_d = sel_found ? S_CLEAR : S_REPORT;
            end
            S_CLEAR: begin
                cmp_clear = 1'b1;
                state_d   = S_REPLAY;
            end
            S_REPLAY: begin
                cmp_data = pkt_buf[rd_q[AW-1:0]];
                if (rd_q == len_q - LW'(1))
                    state_d = S_FLUSH;
            end
            S_FLUSH:  state_d = S_DRAIN;
            S_DRAIN: begin
                if (drain_q == DW'(CMP_LAT - 1))
                    state_d = sel_found ? S_CLEAR : S_REPORT;
            end
            S_REPORT: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && pkt_sop)
            pkt_buf[0] <= pkt_data;
        else if (accept && state_q == S_CAPTURE && len_q < LW'(MAX_WORDS))
            pkt_buf[len_q[AW-1:0]] <= pkt_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TARGETS; i++) slot_ip_q[i] <= '0;
            slot_en_q <= '0;
            len_q     <= '0;
            rd_q      <= '0;
            drain_q   <= '0;
            cur_q     <= '0;
            cmp_ip_q  <= '0;
            ovf_q     <= 1'b0;
            hits_q    <= '0;
        end else begin
            if (cfg_we && int'(cfg_idx) < NUM_TARGETS) begin
                slot_ip_q[cfg_idx] <= cfg_ip;
                slot_en_q[cfg_idx] <= cfg_en;
            end
            case (state_q)
                S_IDLE, S_CAPTURE: begin
                    if (accept && pkt_sop) begin
                        len_q  <= LW'(1);
                        ovf_q  <= 1'b0;
                        hits_q <= '0;
                    end else if (accept && state_q == S_CAPTURE) begin
                        if (len_q < LW'(MAX_WORDS)) len_q <= len_q + LW'(1);
                        else                        ovf_q <= 1'b1;
                    end
                end
                S_CLEAR:  rd_q <= '0;
                S_REPLAY: begin
                    rd_q <= rd_q + LW'(1);
                    // First REPLAY cycle still shows the cleared comparator output.
                    if (rd_q != '0) hits_q[cur_q] <= hits_q[cur_q] | cmp_match;
                end
                S_FLUSH: begin
                    drain_q       <= '0;
                    hits_q[cur_q] <= hits_q[cur_q] | cmp_match;
                end
                S_DRAIN: begin
                    drain_q       <= drain_q + DW'(1);
                    hits_q[cur_q] <= hits_q[cur_q] | cmp_match;
                end
                S_REPORT: begin
                    if (res_ready) begin
                        hits_q <= '0;
                        ovf_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (state_d == S_CLEAR) begin
                cur_q    <= sel_idx;
                cmp_ip_q <= slot_ip_q[sel_idx];
            end
        end
    end

    assign cmp_ip   = cmp_ip_q;
    assign res_hits = hits_q;
    assign res_ovf  = ovf_q;

`ifdef IP_FILTER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts <= '0;
            stat_hits <= '0;
        end else if (res_valid && res_ready) begin
            if (stat_pkts != 16'hFFFF) stat_pkts <= stat_pkts + 16'd1;
            if (|hits_q && stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ip_filter_sequencer.sv
// Directed bench for ip_filter_sequencer with a behavioural two-word-window ip_comparator (CMP_LAT=1).
module tb_ip_filter_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_ip;
    logic        cfg_en;
    logic        pkt_valid, pkt_sop, pkt_eop;
    logic [31:0] pkt_data;
    logic        pkt_ready;
    logic        cmp_clear;
    logic [31:0] cmp_ip, cmp_data;
    logic        cmp_match;
    logic        res_valid, res_ready;
    logic [3:0]  res_hits;
    logic        res_ovf, busy;
`ifdef IP_FILTER_STATS_EN
    logic [15:0] stat_pkts, stat_hits;
`endif

    int checks = 0;
    int failures = 0;
    int clear_cnt = 0;
    logic [31:0] pw [0:31];

    always #5 clk = ~clk;

    ip_filter_sequencer #(.NUM_TARGETS(4), .MAX_WORDS(16), .CMP_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_ip(cfg_ip), .cfg_en(cfg_en),
        .pkt_valid(pkt_valid), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_data(pkt_data),
        .pkt_ready(pkt_ready),
        .cmp_clear(cmp_clear), .cmp_ip(cmp_ip), .cmp_data(cmp_data), .cmp_match(cmp_match),
        .res_valid(res_valid), .res_ready(res_ready), .res_hits(res_hits), .res_ovf(res_ovf),
        .busy(busy)
`ifdef IP_FILTER_STATS_EN
        , .stat_pkts(stat_pkts), .stat_hits(stat_hits)
`endif
    );

    // Comparator model: window is {current word, previous word}, match registered one cycle later.
    logic [31:0] cmp_prev;
    logic        cmp_match_q;
    assign cmp_match = cmp_match_q;

    function automatic logic window_hit(input logic [63:0] w, input logic [31:0] ip);
        for (int k = 0; k <= 4; k++)
            if (w[k*8 +: 32] == ip) return 1'b1;
        return 1'b0;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || cmp_clear) begin
            cmp_prev    <= '0;
            cmp_match_q <= 1'b0;
        end else begin
            cmp_prev    <= cmp_data;
            cmp_match_q <= window_hit({cmp_data, cmp_prev}, cmp_ip);
        end
    end

    always @(posedge clk) if (cmp_clear === 1'b1) clear_cnt <= clear_cnt + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [31:0] ip, input logic en);
        cfg_we = 1'b1; cfg_idx = idx; cfg_ip = ip; cfg_en = en;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic do_eop, output logic rdy_ok);
        rdy_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            pkt_valid = 1'b1;
            pkt_sop   = (i == 0);
            pkt_eop   = do_eop && (i == n - 1);
            pkt_data  = pw[i];
            if (pkt_ready !== 1'b1) rdy_ok = 1'b0;
            step();
        end
        pkt_valid = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
    endtask

    // Called right after the eop edge, i.e. at cycle 1.
    task automatic wait_result(output int cyc);
        cyc = 1;
        while (res_valid !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        int   c0;
        logic rdy;

        rst = 1'b1; cfg_we = 0; cfg_idx = 0; cfg_ip = 0; cfg_en = 0;
        pkt_valid = 0; pkt_sop = 0; pkt_eop = 0; pkt_data = 0; res_ready = 0;
        repeat (3) step();
        check("rst_pkt_ready", pkt_ready, 1);
        check("rst_busy",      busy,      0);
        check("rst_res_valid", res_valid, 0);
        check("rst_cmp_clear", cmp_clear, 0);
        check("rst_cmp_ip",    cmp_ip,    0);
        check("rst_cmp_data",  cmp_data,  0);
        check("rst_res_hits",  res_hits,  0);
        check("rst_res_ovf",   res_ovf,   0);
        rst = 1'b0;
        step();

        // Word without sop in IDLE is ignored
        pkt_valid = 1; pkt_sop = 0; pkt_data = 32'h1234_5678;
        step();
        pkt_valid = 0;
        check("idle_nosop_busy", busy, 0);

        // Test 1
        cfg(2'd0, 32'hC0A8_0101, 1'b1);
        pw[0] = 32'h0000_0000; pw[1] = 32'hC0A8_0101;
        send_pkt(2, 1'b1, rdy);
        wait_result(lat);
        check("t1_latency", lat, 6);
        check("t1_hits", res_hits, 4'b0001);
        check("t1_ovf", res_ovf, 0);
        handshake();

        // Test 2: IP split across words
        pw[0] = 32'h0100_0000; pw[1] = 32'h00C0_A801;
        send_pkt(2, 1'b1, rdy);
        wait_result(lat);
        check("t2_latency", lat, 6);
        check("t2_hits", res_hits, 4'b0001);
        handshake();

        cfg(2'd2, 32'h0A00_0001, 1'b1);
        c0 = clear_cnt;
        send_pkt(2, 1'b1, rdy);
        wait_result(lat);
        check("t2b_latency", lat, 11);
        check("t2b_hits", res_hits, 4'b0001);
        check("t2b_clears", clear_cnt - c0, 2);
        handshake();

        // Test 3: nothing enabled
        cfg(2'd0, 32'hC0A8_0101, 1'b0);
        cfg(2'd2, 32'h0A00_0001, 1'b0);
        pw[0] = 32'hC0A8_0101; pw[1] = 32'h0A00_0001; pw[2] = 32'h0;
        c0 = clear_cnt;
        send_pkt(3, 1'b1, rdy);
        wait_result(lat);
        check("t3_latency", lat, 1);
        check("t3_hits", res_hits, 4'b0000);
        check("t3_clears", clear_cnt - c0, 0);
        handshake();

        // Test 4: overflow, IP only in a dropped word
        cfg(2'd0, 32'hC0A8_0101, 1'b1);
        for (int i = 0; i < 20; i++) pw[i] = 32'h0;
        pw[18] = 32'hC0A8_0101;
        send_pkt(20, 1'b1, rdy);
        check("t4_ready_capture", rdy, 1);
        wait_result(lat);
        check("t4_latency", lat, 20);
        check("t4_hits", res_hits, 4'b0000);
        check("t4_ovf", res_ovf, 1);
        handshake();

        // sop during CAPTURE restarts the packet and clears overflow
        send_pkt(18, 1'b0, rdy);
        check("rs_busy_capture", busy, 1);
        pw[0] = 32'h0000_0000; pw[1] = 32'hC0A8_0101;
        send_pkt(2, 1'b1, rdy);
        wait_result(lat);
        check("rs_latency", lat, 6);
        check("rs_ovf", res_ovf, 0);
        check("rs_hits", res_hits, 4'b0001);
        handshake();

        // Test 5: result held under backpressure
        send_pkt(2, 1'b1, rdy);
        wait_result(lat);
        check("t5_latency", lat, 6);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t5_hold_valid", res_valid, 1);
            check("t5_hold_hits", res_hits, 4'b0001);
            check("t5_hold_ready", pkt_ready, 0);
        end
        handshake();
        check("t5_post_busy", busy, 0);
        check("t5_post_valid", res_valid, 0);
        check("t5_post_hits", res_hits, 0);
        check("t5_post_ready", pkt_ready, 1);
        pkt_valid = 1; pkt_sop = 1; pkt_eop = 0; pkt_data = 32'h0;
        step();
        check("t5_sop_taken", busy, 1);
        pkt_sop = 0; pkt_eop = 1; pkt_data = 32'hC0A8_0101;
        step();
        pkt_valid = 0; pkt_eop = 0;
        wait_result(lat);
        check("t5_next_latency", lat, 6);
        check("t5_next_hits", res_hits, 4'b0001);
        handshake();

        // Test 6: reset during REPLAY
        pw[0] = 32'hC0A8_0101; pw[1] = 32'h1; pw[2] = 32'h2; pw[3] = 32'h3;
        send_pkt(4, 1'b1, rdy);
        check("t6_clear", cmp_clear, 1);
        step();
        check("t6_replay_word0", cmp_data, 32'hC0A8_0101);
        rst = 1'b1;
        step();
        check("t6_rst_busy", busy, 0);
        check("t6_rst_valid", res_valid, 0);
        check("t6_rst_clear", cmp_clear, 0);
        check("t6_rst_ready", pkt_ready, 1);
        rst = 1'b0;
        step();
        pw[0] = 32'h0; pw[1] = 32'hC0A8_0101;
        c0 = clear_cnt;
        send_pkt(2, 1'b1, rdy);
        wait_result(lat);
        check("t6_latency", lat, 1);
        check("t6_hits", res_hits, 4'b0000);
        check("t6_clears", clear_cnt - c0, 0);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
